alu_uart_if: RTL and testbench

ALU_UART_IF -- requirements
Module: alu_uart_if

---
 rtl/alu_uart_if.sv | 132 +++++++++++++
 tb/tb_alu_uart_if.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_if.sv
// UART-to-ALU sequencer: collects A, B and op-code bytes, runs the ALU, and transmits the result.
// Define ALU_UART_IF_OVF_EN to also transmit the overflow flag as a second byte.
module alu_uart_if #(
    parameter int N    = 8,
    parameter int NSel = 6
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_done,
    input  logic            i_tx_done,
    input  logic [N-1:0]    i_alu_result,
    input  logic            i_alu_ovf,
    output logic [N-1:0]    o_alu_A,
    output logic [N-1:0]    o_alu_B,
    output logic [NSel-1:0] o_alu_Op,
    output logic            o_tx_start,
    output logic [7:0]      o_tx_data,
    output logic            o_busy
);

`ifdef ALU_UART_IF_OVF_EN
    typedef enum logic [3:0] {
        ST_A, ST_B, ST_OP, ST_EXEC, ST_CAPT, ST_SEND, ST_WTX, ST_SEND2, ST_WTX2
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_A, ST_B, ST_OP, ST_EXEC, ST_CAPT, ST_SEND, ST_WTX
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [NSel-1:0] op_q, op_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [7:0]      result_ext;

`ifdef ALU_UART_IF_OVF_EN
    logic            ovf_q, ovf_d;
`else
    logic            unused_ovf;
    assign unused_ovf = i_alu_ovf;
`endif

    always_comb begin
        result_ext         = '0;
        result_ext[N-1:0]  = i_alu_result;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
`ifdef ALU_UART_IF_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_A: if (i_rx_done) begin
                a_d     = i_rx_data[N-1:0];
                state_d = ST_B;
            end
            ST_B: if (i_rx_done) begin
                b_d     = i_rx_data[N-1:0];
                state_d = ST_OP;
            end
            ST_OP: if (i_rx_done) begin
                op_d    = i_rx_data[NSel-1:0];
                state_d = ST_EXEC;
            end
            // ALU registers its result on this edge from the now-stable operands
            ST_EXEC: state_d = ST_CAPT;
            ST_CAPT: begin
                tx_data_d = result_ext;
`ifdef ALU_UART_IF_OVF_EN
                ovf_d     = i_alu_ovf;
`endif
                state_d   = ST_SEND;
            end
            ST_SEND: state_d = ST_WTX;
            ST_WTX: if (i_tx_done) begin
`ifdef ALU_UART_IF_OVF_EN
                tx_data_d = {7'b0, ovf_q};
                state_d   = ST_SEND2;
`else
                state_d   = ST_A;
`endif
            end
`ifdef ALU_UART_IF_OVF_EN
            ST_SEND2: state_d = ST_WTX2;
            ST_WTX2: if (i_tx_done) state_d = ST_A;
`endif
            default: state_d = ST_A;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
`ifdef ALU_UART_IF_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
`ifdef ALU_UART_IF_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign o_alu_A   = a_q;
    assign o_alu_B   = b_q;
    assign o_alu_Op  = op_q;
    assign o_tx_data = tx_data_q;
    assign o_busy    = !((state_q == ST_A) || (state_q == ST_B) || (state_q == ST_OP));
`ifdef ALU_UART_IF_OVF_EN
    assign o_tx_start = (state_q == ST_SEND) || (state_q == ST_SEND2);
`else
    assign o_tx_start = (state_q == ST_SEND);
`endif

endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if: vector table of transactions against a registered ALU model,
// a transmit scoreboard, plus reset, stray-byte and N=4 sequences.
module tb_alu_uart_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_res = '0;
    logic       alu_ovf = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic       tx_start, busy;
    logic [7:0] tx_data;

    logic [7:0] r4_data = '0;
    logic       r4_done = 1'b0;
    logic       t4_done = 1'b0;
    logic [3:0] res4 = 4'hC;
    logic [3:0] a4, b4;
    logic [5:0] op4;
    logic       tx4_start, busy4;
    logic [7:0] tx4_data;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_uart_if #(.N(8), .NSel(6)) dut (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_alu_result(alu_res), .i_alu_ovf(alu_ovf),
        .o_alu_A(alu_a), .o_alu_B(alu_b), .o_alu_Op(alu_op),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy)
    );

    alu_uart_if #(.N(4), .NSel(6)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_rx_data(r4_data), .i_rx_done(r4_done),
        .i_tx_done(t4_done), .i_alu_result(res4), .i_alu_ovf(1'b0),
        .o_alu_A(a4), .o_alu_B(b4), .o_alu_Op(op4),
        .o_tx_start(tx4_start), .o_tx_data(tx4_data), .o_busy(busy4)
    );

    // Registered ALU: result appears one clock after the operands
    always @(posedge clk) begin
        logic [8:0] s;
        s = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_op)
            6'h20: begin
                alu_res <= s[7:0];
                alu_ovf <= (alu_a[7] == alu_b[7]) && (s[7] != alu_a[7]);
            end
            6'h22: begin alu_res <= alu_a - alu_b; alu_ovf <= 1'b0; end
            6'h24: begin alu_res <= alu_a & alu_b; alu_ovf <= 1'b0; end
            6'h25: begin alu_res <= alu_a | alu_b; alu_ovf <= 1'b0; end
            6'h26: begin alu_res <= alu_a ^ alu_b; alu_ovf <= 1'b0; end
            default: begin alu_res <= 8'h00; alu_ovf <= 1'b0; end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every transmit pulse pops one expected byte; pulses must be one cycle wide
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (prev_start) check("tx_start_width", {31'b0, tx_start}, 32'd0);
        if (tx_start && !prev_start) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx", {24'b0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_start <= tx_start;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_tx(input string name, output int k);
        k = 1;
        while (!tx_start && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!tx_start) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic ack_tx;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] res, input logic ovf, input bit inject);
        int k;
        exp_q.push_back(res);
`ifdef ALU_UART_IF_OVF_EN
        exp_q.push_back({7'b0, ovf});
`endif
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_tx("tx1", k);
        check("latency", k, 32'd3);
        if (inject) begin
            @(negedge clk);
            send_byte(8'hAA);
            check("busy_in_wtx", {31'b0, busy}, 32'd1);
        end
        ack_tx();
`ifdef ALU_UART_IF_OVF_EN
        wait_tx("tx2", k);
        ack_tx();
`endif
        @(negedge clk);
        check("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] a, b, op, res, exp_op;
        logic       ovf;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int k;
        vecs[0] = '{a:8'h05, b:8'h03, op:8'h20, res:8'h08, exp_op:8'h20, ovf:1'b0};
        vecs[1] = '{a:8'h7F, b:8'h01, op:8'h20, res:8'h80, exp_op:8'h20, ovf:1'b1};
        vecs[2] = '{a:8'h0A, b:8'h03, op:8'h22, res:8'h07, exp_op:8'h22, ovf:1'b0};
        vecs[3] = '{a:8'hF0, b:8'h3C, op:8'h24, res:8'h30, exp_op:8'h24, ovf:1'b0};
        vecs[4] = '{a:8'h0F, b:8'hF0, op:8'h25, res:8'hFF, exp_op:8'h25, ovf:1'b0};
        vecs[5] = '{a:8'hFF, b:8'h0F, op:8'h26, res:8'hF0, exp_op:8'h26, ovf:1'b0};
        vecs[6] = '{a:8'h80, b:8'h80, op:8'h20, res:8'h00, exp_op:8'h20, ovf:1'b1};
        vecs[7] = '{a:8'hC3, b:8'h55, op:8'hE6, res:8'h96, exp_op:8'h26, ovf:1'b0};

        repeat (2) @(negedge clk);
        check("rst_A", {24'b0, alu_a}, 32'd0);
        check("rst_B", {24'b0, alu_b}, 32'd0);
        check("rst_Op", {26'b0, alu_op}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("rst_tx_start", {31'b0, tx_start}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].ovf, 1'b0);
            check("hold_A", {24'b0, alu_a}, {24'b0, vecs[i].a});
            check("hold_B", {24'b0, alu_b}, {24'b0, vecs[i].b});
            check("hold_Op", {26'b0, alu_op}, {24'b0, vecs[i].exp_op});
        end

        // Reset after the B byte aborts the transaction
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_A", {24'b0, alu_a}, 32'd0);
        check("abort_B", {24'b0, alu_b}, 32'd0);
        check("abort_tx_data", {24'b0, tx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset coinciding with a received byte drops the byte
        @(negedge clk);
        rst = 1'b1;
        rx_data = 8'h33;
        rx_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_done = 1'b0;
        @(negedge clk);
        check("rst_rx_A", {24'b0, alu_a}, 32'd0);
        check("rst_rx_busy", {31'b0, busy}, 32'd0);
        run_txn(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0, 1'b0);
        check("post_rst_A", {24'b0, alu_a}, 32'h0F);
        check("post_rst_B", {24'b0, alu_b}, 32'hF0);
        check("post_rst_Op", {26'b0, alu_op}, 32'h25);

        // Stray tx_done while idle is ignored
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("idle_txdone_busy", {31'b0, busy}, 32'd0);

        // Extra byte arriving in the wait-for-transmit state is dropped
        run_txn(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b1);
        check("aa_A", {24'b0, alu_a}, 32'h05);
        run_txn(8'h01, 8'h02, 8'h20, 8'h03, 1'b0, 1'b0);
        check("after_aa_A", {24'b0, alu_a}, 32'h01);

        // Reset while waiting for the transmitter clears the outgoing byte
        exp_q.push_back(8'h09);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h20);
        wait_tx("tx_rst", k);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("wtx_rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("wtx_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Narrow datapath: upper received bits discarded, result zero-extended
        @(negedge clk);
        r4_data = 8'hFE; r4_done = 1'b1; @(negedge clk); r4_done = 1'b0;
        @(negedge clk);
        r4_data = 8'h01; r4_done = 1'b1; @(negedge clk); r4_done = 1'b0;
        @(negedge clk);
        r4_data = 8'h20; r4_done = 1'b1; @(negedge clk); r4_done = 1'b0;
        check("n4_A", {28'b0, a4}, 32'hE);
        k = 1;
        while (!tx4_start && k < 40) begin @(negedge clk); k++; end
        check("n4_latency", k, 32'd3);
        check("n4_tx_data", {24'b0, tx4_data}, 32'h0C);
        @(negedge clk); t4_done = 1'b1; @(negedge clk); t4_done = 1'b0;
`ifdef ALU_UART_IF_OVF_EN
        k = 1;
        while (!tx4_start && k < 40) begin @(negedge clk); k++; end
        check("n4_ovf_start", {31'b0, tx4_start}, 32'd1);
        check("n4_ovf_data", {24'b0, tx4_data}, 32'h00);
        @(negedge clk); t4_done = 1'b1; @(negedge clk); t4_done = 1'b0;
`endif
        @(negedge clk);
        check("n4_busy", {31'b0, busy4}, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
